// File: rtl/hs_link_arbiter.sv
// N-channel stream concentrator: per-channel FIFOs merged onto one tagged output
// stream by packet-locked round-robin arbitration.
module hs_link_arbiter #(
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 16,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     MIB_MASTER_RESET,
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  input  logic [NUM_CH-1:0]        i_valid,
  input  logic [NUM_CH-1:0]        i_last,
  output logic [NUM_CH-1:0]        o_ready,
  input  logic [NUM_CH-1:0]        i_ch_en,
  output logic [DATA_W-1:0]        o_data,
  output logic [CH_W-1:0]          o_ch,
  output logic                     o_last,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [NUM_CH-1:0]        o_fifo_empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {IDLE, LOCK} state_t;

  logic [DATA_W:0]   mem     [NUM_CH][FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr  [NUM_CH];
  logic [PW-1:0]     wr_vis  [NUM_CH];
  logic [PW-1:0]     rd_ptr  [NUM_CH];
  logic [DATA_W:0]   head    [NUM_CH];
  logic [NUM_CH-1:0] ready_r;
  logic [NUM_CH-1:0] empty;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;

  state_t            state;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   lock_ch;
  logic              grant_ok;
  logic [CH_W-1:0]   grant_ch;
  logic [CH_W:0]     scan_idx;
  logic [DATA_W:0]   head_sel;
  logic              can_load;
  logic              load;

  // Emptiness is judged against a one-cycle-delayed copy of the write pointer,
  // so a fresh beat becomes poppable only on the cycle after it was written.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      empty[c] = (wr_vis[c] == rd_ptr[c]);
      push[c]  = i_valid[c] & ready_r[c];
      head[c]  = mem[c][rd_ptr[c][AW-1:0]];
    end
  end

  assign o_ready      = ready_r;
  assign o_fifo_empty = empty;

  always_ff @(posedge clk) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (push[c]) mem[c][wr_ptr[c][AW-1:0]] <= {i_last[c], i_data[c*DATA_W +: DATA_W]};
    end
  end

  always_ff @(posedge clk) begin
    if (!MIB_MASTER_RESET) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        wr_vis[c] <= '0;
        rd_ptr[c] <= '0;
      end
      ready_r <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c]  <= wr_ptr[c] + PW'(push[c]);
        rd_ptr[c]  <= rd_ptr[c] + PW'(pop[c]);
        wr_vis[c]  <= wr_ptr[c];
        ready_r[c] <= ((wr_ptr[c] + PW'(push[c])) - (rd_ptr[c] + PW'(pop[c]))) != PW'(FIFO_DEPTH);
      end
    end
  end

  // Scan from the highest rotation offset down so the nearest channel to rr_ptr wins.
  always_comb begin
    grant_ok = 1'b0;
    grant_ch = '0;
    scan_idx = '0;
    if (state == LOCK) begin
      grant_ok = !empty[lock_ch];
      grant_ch = lock_ch;
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        scan_idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
        if (scan_idx >= (CH_W+1)'(NUM_CH)) scan_idx = scan_idx - (CH_W+1)'(NUM_CH);
        if (!empty[scan_idx[CH_W-1:0]] && i_ch_en[scan_idx[CH_W-1:0]]) begin
          grant_ok = 1'b1;
          grant_ch = scan_idx[CH_W-1:0];
        end
      end
    end
  end

  assign can_load = !o_valid || i_ready;
  assign load     = grant_ok && can_load;
  assign pop      = load ? (NUM_CH'(1) << grant_ch) : '0;
  assign head_sel = head[grant_ch];

  always_ff @(posedge clk) begin
    if (!MIB_MASTER_RESET) begin
      state   <= IDLE;
      rr_ptr  <= '0;
      lock_ch <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ch    <= '0;
      o_last  <= 1'b0;
    end else if (load) begin
      o_valid <= 1'b1;
      o_data  <= head_sel[DATA_W-1:0];
      o_last  <= head_sel[DATA_W];
      o_ch    <= grant_ch;
      if (head_sel[DATA_W]) begin
        state  <= IDLE;
        rr_ptr <= (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + 1'b1;
      end else begin
        state   <= LOCK;
        lock_ch <= grant_ch;
      end
    end else if (i_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
